// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MIN_LEN = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // A pattern length is usable only within [MIN_LEN, max_len].
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= MIN_LEN) && (len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones, clear on rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Mealy serial pattern detector with saturating match count.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               w,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam int unsigned HIST_W = MAX_LEN - 1;

  state_e             state;
  logic [HIST_W-1:0]  history;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] pat_q;
  logic               ovl_q;

  logic               cfg_legal;
  logic               accept;
  logic               window_ok;
  logic               pat_eq;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  assign cfg_legal = len_legal(32'(cfg_len), MAX_LEN);
  assign accept    = (state == ARMED) && din_valid && !cfg_load;
  assign cand      = {history, din};
  assign window_ok = (32'(fill) + 32'd1) >= 32'(len_q);
  assign pat_eq    = ((cand ^ pat_q) & mask) == '0;
  assign w         = accept && window_ok && pat_eq;

  // Select only the low len_q bits of the candidate window for comparison.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(i) < 32'(len_q));
    end
  end

  // Mode FSM plus config latch, bit history and fill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      armed   <= 1'b0;
      cfg_err <= 1'b0;
      history <= '0;
      fill    <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
    end else if (cfg_load) begin
      if (cfg_legal) begin
        state   <= ARMED;
        armed   <= 1'b1;
        cfg_err <= 1'b0;
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        history <= '0;
        fill    <= '0;
      end else begin
        state   <= IDLE;
        armed   <= 1'b0;
        cfg_err <= 1'b1;
      end
    end else if (accept) begin
      history <= HIST_W'(cand);
      if (w && !ovl_q) begin
        fill <= '0;
      end else if (fill != LEN_W'(MAX_LEN)) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w),
    .q   (match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed vectors plus a per-cycle reference model.
module tb_seq_detector_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = 3;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               cnt_clr;
  logic               w;
  logic               armed;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .cnt_clr     (cnt_clr),
    .w           (w),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_armed;
  logic       m_err;
  int         m_cnt;
  int         m_len;
  logic [7:0] m_pat;
  logic       m_ovl;
  int         m_since;
  bit         m_hist[$];

  // Expected Mealy output: last m_len received bits (din newest) spell the pattern.
  function automatic logic model_w();
    logic ok;
    logic b;
    ok = m_armed && !cfg_load && din_valid && ((m_since + 1) >= m_len);
    if (ok) begin
      for (int k = 0; k < m_len; k++) begin
        b = (k == 0) ? din : logic'(m_hist[m_hist.size() - k]);
        if (b != m_pat[k]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic model_reset();
    m_armed = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_len   = 0;
    m_pat   = '0;
    m_ovl   = 1'b0;
    m_since = 0;
    m_hist.delete();
  endtask

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  initial begin
    logic ew;
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      ew = model_w();
      chk("w", int'(w), int'(ew));
      chk("armed", int'(armed), int'(m_armed));
      chk("cfg_err", int'(cfg_err), int'(m_err));
      chk("match_count", int'(match_count), m_cnt);
      if (rst) begin
        model_reset();
      end else begin
        if (cnt_clr) m_cnt = 0;
        else if (ew && m_cnt < CNT_MAX) m_cnt++;
        if (cfg_load) begin
          if (int'(cfg_len) >= 2 && int'(cfg_len) <= int'(MAX_LEN)) begin
            m_armed = 1'b1;
            m_err   = 1'b0;
            m_len   = int'(cfg_len);
            m_pat   = cfg_pattern;
            m_ovl   = cfg_overlap;
            m_since = 0;
            m_hist.delete();
          end else begin
            m_armed = 1'b0;
            m_err   = 1'b1;
          end
        end else if (m_armed && din_valid) begin
          m_hist.push_back(din);
          if (ew && !m_ovl) m_since = 0;
          else m_since++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic r, input logic ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic v, input logic d, input logic c, input int ew);
    @(negedge clk);
    #1;
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    din_valid = v; din = d; cnt_clr = c;
    #2;
    if (ew >= 0) chk("w_directed", int'(w), ew);
  endtask

  task automatic bit_in(input logic d, input int ew);
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, 1'b0, ew);
  endtask

  task automatic gap(input logic d);
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, 1'b0, 0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    drive(1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic clear();
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic regs(input string tag, input int a, input int e, input int c);
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk({tag, "_armed"}, int'(armed), a);
    chk({tag, "_cfg_err"}, int'(cfg_err), e);
    chk({tag, "_count"}, int'(match_count), c);
  endtask

  task automatic stream(input logic [7:0] bits, input logic [7:0] ews, input int n);
    for (int i = 0; i < n; i++) bit_in(bits[n-1-i], int'(ews[n-1-i]));
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;

    drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    regs("reset", 0, 0, 0);

    // Overlapping 10010 over 10010010
    load(8'b10010, 4'd5, 1'b1);
    stream(8'b10010010, 8'b00001001, 8);
    regs("ovl", 1, 0, 2);

    // Non-overlapping, same stream
    clear();
    load(8'b10010, 4'd5, 1'b0);
    stream(8'b10010010, 8'b00001000, 8);
    regs("novl", 1, 0, 1);

    // Gaps must not shift history
    clear();
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1, 0);
    gap(1'b0);
    bit_in(1'b0, 0);
    gap(1'b0);
    bit_in(1'b1, 1);
    regs("gap", 1, 0, 1);

    // Illegal length 1 disarms
    load(8'b11, 4'd1, 1'b1);
    regs("len1", 0, 1, 1);
    stream(8'b00001011, 8'b00000000, 4);

    // Full-length all-ones pattern
    load(8'hFF, 4'd8, 1'b0);
    stream(8'hFF, 8'b00000001, 8);
    regs("len8", 1, 0, 2);

    // Over-long and zero lengths are rejected
    load(8'hFF, 4'd9, 1'b0);
    regs("len9", 0, 1, 2);
    load(8'hFF, 4'd0, 1'b0);
    regs("len0", 0, 1, 2);

    // Saturation then clear coincident with a match
    clear();
    load(8'b11, 4'd2, 1'b1);
    stream(8'b00111111, 8'b00011111, 6);
    regs("sat", 1, 0, 3);
    drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    regs("clr_match", 1, 0, 0);

    // cfg_load drops a would-be completing bit
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1, 0);
    bit_in(1'b0, 0);
    drive(1'b0, 1'b1, 8'b101, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    stream(8'b101, 8'b001, 3);
    regs("load_drop", 1, 0, 1);

    // Reset mid-pattern
    bit_in(1'b1, 0);
    bit_in(1'b0, 0);
    drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    stream(8'b101, 8'b000, 3);
    regs("rst_mid", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
